lsu_dmem_port: RTL and testbench
================================

Name: lsu_dmem_port

Overview:
- Load/store unit sitting directly between the RV32I core's execute logic and the data-memory port.
- Accepts one load or store request from the core.
- Generates the per-byte write-enable mask and lane-replicated write data, and drives a variable-latency word-addressed data memory.
- Returns sign- or zero-extended load data through a valid/ready handshake, with a timeout watchdog for hung memory.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in ISSUE+WAIT before aborting with an error.
- CNT_W, 8: width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: LB/LH/LW/LBU/LHU or SB/SH/SW
- req_addr  in  32  byte address (daddr)
- req_wdata  in  32  store data (rv2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: illegal funct3, misaligned access, or timeout
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepts mem_req this cycle
- mem_addr  out  32  word address: req_addr with bits [1:0] forced to 0
- mem_we  out  4  byte write enables
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  raw word read from memory

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE; the counter clears.
  - req_ready=1.
  - All other outputs are 0.
  - A reset during ISSUE or WAIT drops mem_req at once; no response is issued.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - When req_valid&req_ready, capture we/funct3/addr/wdata.
  - Illegal or misaligned request: go to DONE with err=1; no memory access is made.
  - Otherwise: go to ISSUE.
- ISSUE:
  - mem_req=1; mem_addr, mem_we and mem_wdata are held stable until grant.
  - On mem_gnt, a store goes to DONE and a load goes to WAIT.
- WAIT:
  - On mem_rvalid, register the extended data and go to DONE.
  - mem_rvalid in the same cycle as mem_gnt is ignored; the data must arrive at least one cycle after grant.
- DONE:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - req_ready=0 in every state except IDLE.
- Timeout:
  - The counter increments every cycle in ISSUE/WAIT and resets on entry to ISSUE.
  - When it reaches TIMEOUT_CYCLES: go to DONE with err=1, rdata=0, mem_req=0.
  - A stray mem_rvalid arriving in IDLE or DONE is ignored.
- Minimum latency:
  - Accept at cycle 0, mem_req at cycle 1.
  - Store with grant at cycle 1: resp_valid at cycle 2.
  - Load with grant at cycle 1 and rvalid at cycle 2: resp_valid at cycle 3.
- Store lane rules:
  - SB: mem_we = 4'b0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: mem_we = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated x2.
  - SW: mem_we = 4'b1111.
  - mem_we=0 for loads.
- Load extract:
  - Select the byte or half lane by addr[1:0].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes through.
- Illegal funct3:
  - Loads: 3'b011, 3'b110, 3'b111.
  - Stores: any value above 3'b010.

Optional Feature:
- LSU_MISALIGN_TRAP_EN
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]!=0, completes immediately with resp_err=1 and no memory access.
- Undefined: misaligned addresses are silently truncated (half ignores addr[0], word ignores addr[1:0]) and the access proceeds normally with err=0.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - lsu_state_t enum.
  - Functions: byte_mask(funct3, addr_lo), store_replicate(funct3, data), load_extend(funct3, addr_lo, word).
- One natural sub-module: lsu_lane_align, combinational; store mask/replication plus load extraction/extension.
- The FSM and timeout counter stay in the top level.

Test Plan:
1. SB, addr=0x0000_1003, wdata=0x0000_00A5, gnt immediate -> mem_addr=0x1000, mem_we=4'b1000, mem_wdata=0xA5A5A5A5, resp_valid at cycle 2, err=0.
2. LB, addr=0x1002, mem_rdata=0x1280_3456 -> resp_rdata=0xFFFF_FF80. Same access as LBU -> resp_rdata=0x0000_0080.
3. LH, addr=0x2002, mem_rdata=0x8001_7FFF, gnt delayed 3 cycles, rvalid 2 cycles later -> resp_rdata=0xFFFF_8001; req_ready stays 0 throughout.
4. LW, TIMEOUT_CYCLES=4, gnt never asserted -> mem_req drops after 4 cycles in ISSUE; resp_valid with err=1, rdata=0; a later mem_rvalid is ignored.
5. LW, addr=0x3001, run once with LSU_MISALIGN_TRAP_EN defined and once without -> defined: err=1, mem_req never asserted; undefined: mem_addr=0x3000, normal completion.
6. rst_n pulled low mid-WAIT -> mem_req, resp_valid and resp_err are 0 immediately and req_ready=1; a new SW request after reset completes with mem_we=4'b1111.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit data-memory port.
//   - RV32I funct3 encodings for the width/sign field of loads and stores
//   - lsu_state_t: request sequencing states
//   - byte_mask / store_replicate: store lane placement
//   - load_extend: load lane selection and sign/zero extension
//   - illegal_funct3 / addr_misaligned: request legality checks
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_t;

  // Byte enables for a store. A misaligned half/word is truncated to its
  // naturally aligned container (half uses addr[1] only, word ignores both).
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic [3:0] mask_s;
    case (funct3)
      F3_B:    mask_s = 4'b0001 << addr_lo;
      F3_H:    mask_s = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:    mask_s = 4'b1111;
      default: mask_s = 4'b0000;
    endcase
    return mask_s;
  endfunction

  // Copy the store datum onto every lane so the byte enables alone pick
  // where it lands.
  function automatic logic [31:0] store_replicate(input logic [2:0]  funct3,
                                                  input logic [31:0] data);
    logic [31:0] rep_s;
    case (funct3)
      F3_B:    rep_s = {4{data[7:0]}};
      F3_H:    rep_s = {2{data[15:0]}};
      F3_W:    rep_s = data;
      default: rep_s = 32'h0000_0000;
    endcase
    return rep_s;
  endfunction

  // Pick the addressed byte/half out of the raw word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo,
                                              input logic [31:0] word);
    logic [7:0]  b_s;
    logic [15:0] h_s;
    logic [31:0] r_s;
    case (addr_lo)
      2'b00:   b_s = word[7:0];
      2'b01:   b_s = word[15:8];
      2'b10:   b_s = word[23:16];
      2'b11:   b_s = word[31:24];
      default: b_s = 8'h00;
    endcase
    h_s = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    r_s = {{24{b_s[7]}}, b_s};
      F3_BU:   r_s = {24'h00_0000, b_s};
      F3_H:    r_s = {{16{h_s[15]}}, h_s};
      F3_HU:   r_s = {16'h0000, h_s};
      F3_W:    r_s = word;
      default: r_s = 32'h0000_0000;
    endcase
    return r_s;
  endfunction

  // Loads reserve 011/110/111; stores only define 000..010.
  function automatic logic illegal_funct3(input logic       we,
                                          input logic [2:0] funct3);
    logic ill_s;
    if (we) begin
      ill_s = (funct3 > F3_W);
    end else begin
      ill_s = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    return ill_s;
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic mis_s;
    case (funct3)
      F3_H, F3_HU: mis_s = addr_lo[0];
      F3_W:        mis_s = (addr_lo != 2'b00);
      default:     mis_s = 1'b0;
    endcase
    return mis_s;
  endfunction

endpackage

// File: rtl/lsu_dmem_port_if.sv
// Core-request / response / data-memory bundle of the load/store unit.
//   slave  : the LSU (accepts core requests, drives the memory port)
//   master : the environment (core execute stage plus data memory)
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : core request
//   resp_valid/resp_rdata/resp_err                          : completion
//   mem_req/mem_gnt/mem_addr/mem_we/mem_wdata               : memory command
//   mem_rvalid/mem_rdata                                    : memory read data
interface lsu_dmem_port_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment for the LSU.
//   st_*  : store side - byte enables and lane-replicated write data from
//           the incoming request (enables forced to 0 for loads)
//   ld_*  : load side - byte/half selection and sign/zero extension of the
//           raw memory word using the captured funct3 and addr[1:0]
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        st_we,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  // Store lane placement; a load never writes.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'h0000_0000;
    if (st_we) begin
      st_be    = byte_mask(st_funct3, st_addr_lo);
      st_wdata = store_replicate(st_funct3, st_data);
    end else begin
      st_be    = 4'b0000;
      st_wdata = 32'h0000_0000;
    end
  end

  // Load lane extraction and extension.
  always_comb begin
    ld_data = load_extend(ld_funct3, ld_addr_lo, ld_word);
  end

endmodule

// File: rtl/lsu_dmem_port.sv
// RV32I load/store unit between the execute stage and a variable-latency,
// word-addressed data memory.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lsu_dmem_port_if.slave (core request/response + memory port)
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed in ISSUE+WAIT before aborting with error
//   CNT_W          : timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
// Build option:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses
//   complete at once with resp_err=1; otherwise they are truncated to the
//   aligned container and proceed normally.
// All outputs are registered. A request is sequenced IDLE -> ISSUE ->
// (WAIT for loads) -> DONE, or IDLE -> DONE when it is rejected up front.
module lsu_dmem_port
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_dmem_port_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             we_r;
  logic [2:0]       funct3_r;
  logic [1:0]       addr_lo_r;

  logic             bad_s;
  logic             last_s;
  logic [3:0]       st_be_s;
  logic [31:0]      st_wdata_s;
  logic [31:0]      ld_data_s;

  lsu_lane_align u_lane_align (
    .st_we      (bus.req_we),
    .st_funct3  (bus.req_funct3),
    .st_addr_lo (bus.req_addr[1:0]),
    .st_data    (bus.req_wdata),
    .st_be      (st_be_s),
    .st_wdata   (st_wdata_s),
    .ld_funct3  (funct3_r),
    .ld_addr_lo (addr_lo_r),
    .ld_word    (bus.mem_rdata),
    .ld_data    (ld_data_s)
  );

  // Reject an incoming request that must not touch memory.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    bad_s = illegal_funct3(bus.req_we, bus.req_funct3) |
            addr_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
    bad_s = illegal_funct3(bus.req_we, bus.req_funct3);
`endif
  end

  // Final cycle of the ISSUE+WAIT budget.
  always_comb begin
    last_s = (cnt_r == CNT_LAST_C);
  end

  // Request sequencer, timeout counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      we_r           <= 1'b0;
      funct3_r       <= 3'b000;
      addr_lo_r      <= 2'b00;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'h0000_0000;
      bus.resp_err   <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= 32'h0000_0000;
      bus.mem_we     <= 4'b0000;
      bus.mem_wdata  <= 32'h0000_0000;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_r          <= bus.req_we;
            funct3_r      <= bus.req_funct3;
            addr_lo_r     <= bus.req_addr[1:0];
            bus.req_ready <= 1'b0;
            if (bad_s) begin
              state_r        <= ST_DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'h0000_0000;
            end else begin
              state_r       <= ST_ISSUE;
              cnt_r         <= '0;
              bus.mem_req   <= 1'b1;
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              bus.mem_we    <= st_be_s;
              bus.mem_wdata <= st_wdata_s;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end

        ST_ISSUE: begin
          // A load granted on the last budgeted cycle could never return
          // in time, so the timeout wins; a store finishes at grant.
          if (bus.mem_gnt && (we_r || !last_s)) begin
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= 32'h0000_0000;
            bus.mem_we    <= 4'b0000;
            bus.mem_wdata <= 32'h0000_0000;
            cnt_r         <= cnt_r + CNT_W'(1);
            if (we_r) begin
              state_r        <= ST_DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b0;
              bus.resp_rdata <= 32'h0000_0000;
            end else begin
              state_r <= ST_WAIT;
            end
          end else if (last_s) begin
            state_r        <= ST_DONE;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= 32'h0000_0000;
            bus.mem_we     <= 4'b0000;
            bus.mem_wdata  <= 32'h0000_0000;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        ST_WAIT: begin
          if (bus.mem_rvalid) begin
            state_r        <= ST_DONE;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= ld_data_s;
          end else if (last_s) begin
            state_r        <= ST_DONE;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        ST_DONE: begin
          state_r        <= ST_IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= 32'h0000_0000;
        end

        default: begin
          state_r        <= ST_IDLE;
          cnt_r          <= '0;
          bus.req_ready  <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= 32'h0000_0000;
          bus.mem_req    <= 1'b0;
          bus.mem_addr   <= 32'h0000_0000;
          bus.mem_we     <= 4'b0000;
          bus.mem_wdata  <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Scoreboard bench for lsu_dmem_port. The driver issues requests and plays
// the memory; expected memory commands and responses are derived from the
// RV32I load/store rules and queued; monitors on the falling edge pop and
// compare whenever the DUT raises mem_req or resp_valid.
module tb_lsu_dmem_port;

  localparam int T = 8;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    bit          st;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_dmem_port_if bus ();

  lsu_dmem_port #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  resp_t resp_q[$];
  beat_t beat_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    busy = 1'b0;
  bit    in_rst = 1'b1;
  logic  mem_req_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_bad(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit ill, mis;
    ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = TRAP_EN && (((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0));
    return ill || mis;
  endfunction

  // Bytes [off, off+size) of the word, with off truncated to the size.
  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    int size, off;
    logic [3:0] m;
    size = 1 << f3[1:0];
    off  = int'(a[1:0]) / size * size;
    m = 4'b0000;
    for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + size);
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    else if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    else return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'h1_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon
    beat_t b;
    resp_t r;
    if (!in_rst) begin
      check("req_ready", 32'(bus.req_ready), 32'(!busy));
      if (bus.mem_req && !mem_req_prev) begin
        if (beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_req: unexpected memory request at cycle %0d", cyc);
        end else begin
          b = beat_q.pop_front();
          check("mem_addr", bus.mem_addr, b.addr);
          check("mem_we", 32'(bus.mem_we), 32'(b.we));
          if (b.st) check("mem_wdata", bus.mem_wdata, b.wdata);
        end
      end
      if (bus.resp_valid) begin
        check("mem_req_at_resp", 32'(bus.mem_req), 32'd0);
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp: unexpected resp_valid at cycle %0d", cyc);
        end else begin
          r = resp_q.pop_front();
          check("resp_rdata", bus.resp_rdata, r.rdata);
          check("resp_err", 32'(bus.resp_err), 32'(r.err));
          check("resp_cycle", 32'(cyc), 32'(r.cyc));
        end
        busy = 1'b0;
      end
    end
    mem_req_prev = bus.mem_req;
  end

  // ---------------- driver / memory model ----------------
  // gd: cycles mem_req waits before grant (>= T means never granted)
  // rd: cycles from grant to read data (>= 1)
  task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gd, input int rd,
                        input logic [31:0] word, input bit rst_mid);
    int    n, base;
    resp_t r;
    beat_t b;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_wait: req_ready stayed 0 for %0d cycles", n);
    end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_wdata = $urandom; bus.req_addr = $urandom;
    busy = 1'b1;
    base = cyc;
    if (m_bad(we, f3, addr)) begin
      r.rdata = 32'd0; r.err = 1'b1; r.cyc = base;
      resp_q.push_back(r);
    end else begin
      b.addr = addr & ~32'd3; b.we = we ? m_mask(f3, addr) : 4'b0000;
      b.wdata = m_wdata(f3, wdata); b.st = we;
      beat_q.push_back(b);
      r.rdata = 32'd0; r.err = 1'b1; r.cyc = base + T;
      if (gd < T && we) begin
        r.err = 1'b0; r.cyc = base + gd + 1;
      end else if (gd < T && gd + rd <= T - 1) begin
        r.rdata = m_load(f3, addr, word); r.err = 1'b0; r.cyc = base + gd + rd + 1;
      end
      resp_q.push_back(r);
      repeat (gd) begin @(posedge clk); #1; end
      if (gd < T) begin
        bus.mem_gnt = 1'b1;
        if (!we) begin
          bus.mem_rvalid = 1'b1; bus.mem_rdata = ~word;
        end
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        if (rst_mid) begin
          repeat (2) @(posedge clk);
          #3;
          in_rst = 1'b1;
          rst_n = 1'b0;
          #1;
          check("rst_mem_req", 32'(bus.mem_req), 32'd0);
          check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
          check("rst_resp_err", 32'(bus.resp_err), 32'd0);
          check("rst_req_ready", 32'(bus.req_ready), 32'd1);
          resp_q.delete(); beat_q.delete(); busy = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1; in_rst = 1'b0;
          return;
        end
        if (!we) begin
          repeat (rd - 1) begin @(posedge clk); #1; end
          bus.mem_rvalid = 1'b1; bus.mem_rdata = word;
          @(posedge clk); #1;
          bus.mem_rvalid = 1'b0;
        end
      end else begin
        bus.mem_rvalid = 1'b1; bus.mem_rdata = word;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
      end
    end
    n = 0;
    while (busy && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL resp_wait: no resp_valid within %0d cycles", n);
      busy = 1'b0; resp_q.delete(); beat_q.delete();
    end
  endtask

  initial begin
    bit          we;
    logic [2:0]  f3;
    int          gd, rd;
    logic [2:0]  ld_legal [5];
    ld_legal[0] = 3'd0; ld_legal[1] = 3'd1; ld_legal[2] = 3'd2;
    ld_legal[3] = 3'd4; ld_legal[4] = 3'd5;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_mem_req", 32'(bus.mem_req), 32'd0);
    check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset_resp_err", 32'(bus.resp_err), 32'd0);
    check("reset_resp_rdata", bus.resp_rdata, 32'd0);
    check("reset_mem_we", 32'(bus.mem_we), 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    rst_n = 1'b1;
    in_rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    do_txn(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 0, 1, 32'd0, 1'b0);       // SB
    do_txn(1'b0, 3'd0, 32'h0000_1002, 32'd0, 0, 1, 32'h1280_3456, 1'b0);       // LB
    do_txn(1'b0, 3'd4, 32'h0000_1002, 32'd0, 0, 1, 32'h1280_3456, 1'b0);       // LBU
    do_txn(1'b0, 3'd1, 32'h0000_2002, 32'd0, 3, 2, 32'h8001_7FFF, 1'b0);       // LH slow
    do_txn(1'b0, 3'd2, 32'h0000_4000, 32'd0, T, 1, 32'hDEAD_BEEF, 1'b0);       // timeout + stray
    do_txn(1'b0, 3'd2, 32'h0000_3001, 32'd0, 0, 1, 32'h0123_4567, 1'b0);       // misaligned LW
    do_txn(1'b1, 3'd1, 32'h0000_3003, 32'h1234_BEEF, 1, 1, 32'd0, 1'b0);       // misaligned SH
    do_txn(1'b1, 3'd3, 32'h0000_3000, 32'h1111_1111, 0, 1, 32'd0, 1'b0);       // illegal store
    do_txn(1'b0, 3'd6, 32'h0000_3000, 32'd0, 0, 1, 32'h5555_5555, 1'b0);       // illegal load
    do_txn(1'b0, 3'd5, 32'h0000_3002, 32'd0, 2, T - 3, 32'hF00D_8642, 1'b0);   // last cycle ok
    do_txn(1'b0, 3'd5, 32'h0000_3002, 32'd0, 2, T - 2, 32'hF00D_8642, 1'b0);   // one too late
    do_txn(1'b1, 3'd2, 32'h0000_3004, 32'hABCD_0123, T - 1, 1, 32'd0, 1'b0);   // store grant last cycle
    do_txn(1'b0, 3'd2, 32'h0000_3008, 32'd0, T - 1, 1, 32'h7777_7777, 1'b0);   // load grant last cycle
    do_txn(1'b0, 3'd2, 32'h0000_5000, 32'd0, 0, 5, 32'h2468_ACE0, 1'b1);       // reset mid-WAIT
    do_txn(1'b1, 3'd2, 32'h0000_6000, 32'hCAFE_F00D, 0, 1, 32'd0, 1'b0);       // SW after reset

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) f3 = we ? 3'($urandom_range(0, 2)) : ld_legal[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      gd = ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, 3);
      rd = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 3, T + 1) : $urandom_range(1, 3);
      do_txn(we, f3, $urandom, $urandom, gd, rd, $urandom, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    if (resp_q.size() != 0 || beat_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d responses and %0d memory commands never seen", resp_q.size(), beat_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
